// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by the port arbiter.
// The slave view is the arbiter; the master view is the pipeline plus memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;
  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_W/8-1:0]   dm_be;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_valid;
  logic                  stall_if;
  logic                  stall_mem;
  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// load/store, one access at a time, data side first.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [3:0]  LatM1 = 4'(MEM_LAT - 1);

  typedef enum logic {StIdle, StWait} state_e;
  typedef enum logic {OwnIf, OwnDm} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                store_q, store_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  logic                dm_elig, if_elig;
  logic                mem_en, mem_we;
  logic [BE_W-1:0]     mem_be;
  logic [ADDR_W-1:0]   mem_addr;

  // A requester is not eligible in its own valid cycle, so a held req cannot re-grant.
  assign dm_elig = bus.dm_req & ~dm_valid_q;
  assign if_elig = bus.if_req & ~if_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= OwnIf;
      cnt_q      <= 4'd0;
      store_q    <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      store_q    <= store_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    store_d    = store_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (dm_elig) begin
          owner_d = OwnDm;
          store_d = bus.dm_we;
          cnt_d   = LatM1;
          state_d = StWait;
        end else if (if_elig) begin
          owner_d = OwnIf;
          store_d = 1'b0;
          cnt_d   = LatM1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
          if (owner_q == OwnDm) begin
            dm_valid_d = 1'b1;
            // Stores complete with a pulse but leave the last load data intact.
            if (!store_q) dm_rdata_d = bus.mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_be   = '1;
    mem_addr = dm_elig ? bus.dm_addr : bus.if_addr;
    if (rst_n && state_q == StIdle) begin
      if (dm_elig) begin
        mem_en = 1'b1;
        mem_we = bus.dm_we;
        mem_be = bus.dm_we ? bus.dm_be : '1;
      end else if (if_elig) begin
        mem_en = 1'b1;
      end
    end
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_be    = mem_be;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = bus.dm_wdata;

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at MEM_LAT=1 and one at MEM_LAT=3, each with a
// small word-addressed memory model behind it.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_bad;
  int   en_cnt1;
  int   en_cnt3;
  int   ec0;

  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] rd1;
  logic [31:0] rd3_0, rd3_1, rd3_2;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus1.mem_en) begin
      if (bus1.mem_we)
        mem1[bus1.mem_addr[7:2]] <= merge(mem1[bus1.mem_addr[7:2]], bus1.mem_wdata, bus1.mem_be);
      rd1 <= mem1[bus1.mem_addr[7:2]];
      en_cnt1 <= en_cnt1 + 1;
    end
  end
  assign bus1.mem_rdata = rd1;

  always @(posedge clk) begin
    rd3_0 <= bus3.mem_en ? mem3[bus3.mem_addr[7:2]] : 32'h0;
    rd3_1 <= rd3_0;
    rd3_2 <= rd3_1;
    if (bus3.mem_en) en_cnt3 <= en_cnt3 + 1;
  end
  assign bus3.mem_rdata = rd3_2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_bad    = 0;
    en_cnt1  = 0;
    en_cnt3  = 0;
    rd1 = 32'h0; rd3_0 = 32'h0; rd3_1 = 32'h0; rd3_2 = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    mem1[4]  = 32'h00500093;  // 0x10
    mem1[8]  = 32'hA5A50001;  // 0x20
    mem1[16] = 32'h11223344;  // 0x40
    mem1[17] = 32'h0BADF00D;  // 0x44
    mem3[0]  = 32'h00000013;
    mem3[1]  = 32'h00100093;

    rst_n = 1'b0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.dm_req = 0; bus1.dm_we = 0;
    bus1.dm_be = 0; bus1.dm_addr = 0; bus1.dm_wdata = 0;
    bus3.if_req = 0; bus3.if_addr = 0; bus3.dm_req = 0; bus3.dm_we = 0;
    bus3.dm_be = 0; bus3.dm_addr = 0; bus3.dm_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_if_valid", bus1.if_valid, 0);
    check_eq("rst_dm_valid", bus1.dm_valid, 0);
    check_eq("rst_if_rdata", bus1.if_rdata, 0);
    check_eq("rst_dm_rdata", bus1.dm_rdata, 0);
    check_eq("rst_mem_en", bus1.mem_en, 0);
    check_eq("rst_stall_if", bus1.stall_if, 0);

    // Single fetch, request held through its valid cycle
    tick();
    ec0 = en_cnt1;
    bus1.if_req = 1; bus1.if_addr = 32'h10;
    @(negedge clk);
    check_eq("t1_c0_en", bus1.mem_en, 1);
    check_eq("t1_c0_addr", bus1.mem_addr, 32'h10);
    check_eq("t1_c0_we", bus1.mem_we, 0);
    check_eq("t1_c0_be", bus1.mem_be, 4'hF);
    check_eq("t1_c0_stall", bus1.stall_if, 1);
    tick();
    @(negedge clk);
    check_eq("t1_c1_en", bus1.mem_en, 0);
    check_eq("t1_c1_valid", bus1.if_valid, 0);
    check_eq("t1_c1_stall", bus1.stall_if, 1);
    tick();
    @(negedge clk);
    check_eq("t1_c2_valid", bus1.if_valid, 1);
    check_eq("t1_c2_rdata", bus1.if_rdata, 32'h00500093);
    check_eq("t1_c2_stall", bus1.stall_if, 0);
    check_eq("t1_c2_no_regrant", bus1.mem_en, 0);
    tick();
    bus1.if_req = 0;
    @(negedge clk);
    check_eq("t1_c3_valid", bus1.if_valid, 0);
    check_eq("t1_c3_hold", bus1.if_rdata, 32'h00500093);
    check_eq("t1_one_en", en_cnt1 - ec0, 1);

    // Simultaneous load and fetch: data side first
    tick();
    bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_be = 4'h0; bus1.dm_addr = 32'h40;
    bus1.if_req = 1; bus1.if_addr = 32'h20;
    @(negedge clk);
    check_eq("t2_c0_en", bus1.mem_en, 1);
    check_eq("t2_c0_addr", bus1.mem_addr, 32'h40);
    check_eq("t2_c0_be", bus1.mem_be, 4'hF);
    tick();
    @(negedge clk);
    check_eq("t2_c1_en", bus1.mem_en, 0);
    check_eq("t2_c1_stall_if", bus1.stall_if, 1);
    check_eq("t2_c1_stall_mem", bus1.stall_mem, 1);
    tick();
    @(negedge clk);
    check_eq("t2_c2_dm_valid", bus1.dm_valid, 1);
    check_eq("t2_c2_dm_rdata", bus1.dm_rdata, 32'h11223344);
    check_eq("t2_c2_stall_mem", bus1.stall_mem, 0);
    check_eq("t2_c2_if_en", bus1.mem_en, 1);
    check_eq("t2_c2_if_addr", bus1.mem_addr, 32'h20);
    tick();
    bus1.dm_req = 0;
    @(negedge clk);
    check_eq("t2_c3_dm_valid", bus1.dm_valid, 0);
    check_eq("t2_c3_en", bus1.mem_en, 0);
    check_eq("t2_c3_if_valid", bus1.if_valid, 0);
    tick();
    @(negedge clk);
    check_eq("t2_c4_if_valid", bus1.if_valid, 1);
    check_eq("t2_c4_if_rdata", bus1.if_rdata, 32'hA5A50001);
    tick();
    bus1.if_req = 0;

    // Partial store, then read the word back
    tick();
    bus1.dm_req = 1; bus1.dm_we = 1; bus1.dm_be = 4'b0011;
    bus1.dm_addr = 32'h44; bus1.dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check_eq("t3_c0_en", bus1.mem_en, 1);
    check_eq("t3_c0_we", bus1.mem_we, 1);
    check_eq("t3_c0_be", bus1.mem_be, 4'b0011);
    check_eq("t3_c0_addr", bus1.mem_addr, 32'h44);
    check_eq("t3_c0_wdata", bus1.mem_wdata, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check_eq("t3_c1_en", bus1.mem_en, 0);
    tick();
    @(negedge clk);
    check_eq("t3_c2_valid", bus1.dm_valid, 1);
    check_eq("t3_c2_rdata_kept", bus1.dm_rdata, 32'h11223344);
    tick();
    bus1.dm_req = 0; bus1.dm_we = 0;
    tick();
    bus1.dm_req = 1;
    tick();
    tick();
    @(negedge clk);
    check_eq("t3_rb_valid", bus1.dm_valid, 1);
    check_eq("t3_rb_rdata", bus1.dm_rdata, 32'h0BADBEEF);
    tick();
    bus1.dm_req = 0;

    // MEM_LAT=3 consecutive fetches; no re-grant in the valid cycle
    tick();
    ec0 = en_cnt3;
    bus3.if_req = 1; bus3.if_addr = 32'h0;
    @(negedge clk);
    check_eq("t4_c0_en", bus3.mem_en, 1);
    check_eq("t4_c0_addr", bus3.mem_addr, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      @(negedge clk);
      check_eq($sformatf("t4_c%0d_en", c), bus3.mem_en, 0);
      check_eq($sformatf("t4_c%0d_valid", c), bus3.if_valid, 0);
    end
    tick();
    @(negedge clk);
    check_eq("t4_c4_valid", bus3.if_valid, 1);
    check_eq("t4_c4_rdata", bus3.if_rdata, 32'h00000013);
    check_eq("t4_c4_en", bus3.mem_en, 0);
    tick();
    bus3.if_addr = 32'h4;
    @(negedge clk);
    check_eq("t4_c5_en", bus3.mem_en, 1);
    check_eq("t4_c5_addr", bus3.mem_addr, 32'h4);
    for (int c = 6; c <= 8; c++) begin
      tick();
      @(negedge clk);
      check_eq($sformatf("t4_c%0d_en", c), bus3.mem_en, 0);
    end
    tick();
    @(negedge clk);
    check_eq("t4_c9_valid", bus3.if_valid, 1);
    check_eq("t4_c9_rdata", bus3.if_rdata, 32'h00100093);
    tick();
    bus3.if_req = 0;
    @(negedge clk);
    check_eq("t4_en_count", en_cnt3 - ec0, 2);

    // Reset during WAIT aborts the access; pending fetch re-granted after release
    tick();
    bus1.if_req = 1; bus1.if_addr = 32'h10;
    @(negedge clk);
    check_eq("t6_c0_en", bus1.mem_en, 1);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_if_valid", bus1.if_valid, 0);
    check_eq("t6_rst_if_rdata", bus1.if_rdata, 0);
    check_eq("t6_rst_dm_rdata", bus1.dm_rdata, 0);
    check_eq("t6_rst_mem_en", bus1.mem_en, 0);
    check_eq("t6_rst_mem_we", bus1.mem_we, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_rel_en", bus1.mem_en, 1);
    check_eq("t6_rel_addr", bus1.mem_addr, 32'h10);
    check_eq("t6_rel_valid", bus1.if_valid, 0);
    tick();
    @(negedge clk);
    check_eq("t6_w_valid", bus1.if_valid, 0);
    check_eq("t6_w_en", bus1.mem_en, 0);
    tick();
    @(negedge clk);
    check_eq("t6_done_valid", bus1.if_valid, 1);
    check_eq("t6_done_rdata", bus1.if_rdata, 32'h00500093);
    tick();
    bus1.if_req = 0;
    tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
